// File: rtl/gaussian_blur.sv
// Streaming 5x5 Gaussian smoothing stage: reads a raster grayscale frame from a
// FWFT FIFO and writes one smoothed pixel per input pixel (zero on the 2-pixel border).
module gaussian_blur #(
    parameter int unsigned IMG_WIDTH  = 720,
    parameter int unsigned IMG_HEIGHT = 576
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_empty,
    input  logic [7:0] in_dout,
    output logic       in_rd_en,
    input  logic       out_full,
    output logic       out_wr_en,
    output logic [7:0] out_din
);

    localparam int unsigned COL_W  = $clog2(IMG_WIDTH + 2);
    localparam int unsigned ROW_W  = $clog2(IMG_HEIGHT + 2);
    localparam int unsigned ADDR_W = $clog2(IMG_WIDTH);
    localparam int unsigned SUM_W  = 16;
    localparam int unsigned NUM_LB = 4;

    typedef enum logic [1:0] {S_FETCH, S_SUM, S_WRITE, S_ADVANCE} state_t;

    state_t             state, state_nxt;
    logic [ROW_W-1:0]   row, row_nxt;
    logic [COL_W-1:0]   col, col_nxt, rd_col;
    logic [1:0]         wslot;
    logic [7:0]         win [5][5];
    logic [7:0]         lb_rd [NUM_LB];
    logic [SUM_W-1:0]   sum_c, sum_q;
    logic               zero_q;
    logic               need_input, emits, row_end, frame_end, border;
    logic [ADDR_W-1:0]  rd_addr, wr_addr;
    logic               shift_en, lb_we, sum_en, advance_en;

    // Symmetric kernel indexed by distance from the window centre
    function automatic logic [3:0] k_weight(input int i, input int j);
        int di, dj;
        di = (i > 2) ? i - 2 : 2 - i;
        dj = (j > 2) ? j - 2 : 2 - j;
        case (di * 3 + dj)
            0:       k_weight = 4'd15;
            1, 3:    k_weight = 4'd12;
            2, 6:    k_weight = 4'd5;
            4:       k_weight = 4'd9;
            5, 7:    k_weight = 4'd4;
            default: k_weight = 4'd2;
        endcase
    endfunction

    assign need_input = (row < ROW_W'(IMG_HEIGHT)) && (col < COL_W'(IMG_WIDTH));
    assign emits      = (row >= ROW_W'(2)) && (col >= COL_W'(2));
    assign row_end    = (col == COL_W'(IMG_WIDTH + 1));
    assign frame_end  = row_end && (row == ROW_W'(IMG_HEIGHT + 1));
    assign border     = (row < ROW_W'(4)) || (row >= ROW_W'(IMG_HEIGHT)) ||
                        (col < COL_W'(4)) || (col >= COL_W'(IMG_WIDTH));
    assign col_nxt    = row_end ? '0 : col + COL_W'(1);
    assign row_nxt    = !row_end ? row : (frame_end ? '0 : row + ROW_W'(1));

    // During S_ADVANCE the buffers already fetch the next column
    assign rd_col  = (state == S_ADVANCE) ? col_nxt : col;
    assign rd_addr = (rd_col < COL_W'(IMG_WIDTH)) ? ADDR_W'(rd_col) : '0;
    assign wr_addr = ADDR_W'(col);

    // Line buffers: read-before-write so the window captures the old row
    for (genvar g = 0; g < NUM_LB; g++) begin : g_lb
        logic [7:0] mem [IMG_WIDTH];
        logic [7:0] rd_q;
        always_ff @(posedge clk) begin
            if (lb_we && (wslot == 2'(g))) mem[wr_addr] <= in_dout;
            rd_q <= mem[rd_addr];
        end
        assign lb_rd[g] = rd_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_FETCH;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_FETCH:   if (!rst && (!need_input || !in_empty)) state_nxt = S_SUM;
            S_SUM:     state_nxt = S_WRITE;
            S_WRITE:   if (!emits || !out_full) state_nxt = S_ADVANCE;
            S_ADVANCE: state_nxt = S_FETCH;
            default:   state_nxt = S_FETCH;
        endcase
    end

    always_comb begin
        in_rd_en   = 1'b0;
        out_wr_en  = 1'b0;
        shift_en   = 1'b0;
        lb_we      = 1'b0;
        sum_en     = 1'b0;
        advance_en = 1'b0;
        case (state)
            S_FETCH: begin
                if (!rst && need_input && !in_empty) begin
                    in_rd_en = 1'b1;
                    shift_en = 1'b1;
                    lb_we    = 1'b1;
                end else if (!rst && !need_input) begin
                    shift_en = 1'b1;
                end
            end
            S_SUM:     sum_en = 1'b1;
            S_WRITE:   out_wr_en = !rst && emits && !out_full;
            S_ADVANCE: advance_en = 1'b1;
            default:   ;
        endcase
    end

    always_comb begin
        sum_c = '0;
        for (int i = 0; i < 5; i++) begin
            for (int j = 0; j < 5; j++) begin
                sum_c = sum_c + SUM_W'(win[i][j]) * SUM_W'(k_weight(i, j));
            end
        end
    end

    // Window row 0 is row r-4; the slot holding row r-4 is wslot
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row    <= '0;
            col    <= '0;
            wslot  <= '0;
            sum_q  <= '0;
            zero_q <= 1'b1;
            for (int i = 0; i < 5; i++) begin
                for (int j = 0; j < 5; j++) win[i][j] <= '0;
            end
        end else begin
            if (shift_en) begin
                for (int i = 0; i < 5; i++) begin
                    for (int j = 0; j < 4; j++) win[i][j] <= win[i][j + 1];
                end
                for (int i = 0; i < 4; i++) begin
                    win[i][4] <= need_input ? lb_rd[2'(wslot + 2'(i))] : 8'd0;
                end
                win[4][4] <= need_input ? in_dout : 8'd0;
            end
            if (sum_en) begin
                sum_q  <= sum_c;
                zero_q <= border;
            end
            if (advance_en) begin
                col <= col_nxt;
                row <= row_nxt;
                if (row_end) wslot <= wslot + 2'd1;
            end
        end
    end

    assign out_din = zero_q ? 8'd0 : 8'(sum_q / SUM_W'(159));

endmodule

// File: tb/tb_gaussian_blur.sv
// Self-checking bench for gaussian_blur: FIFO-style driver, golden-model scoreboard.
module tb_gaussian_blur;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_empty = 1'b1;
    logic       out_full = 1'b0;
    logic [7:0] in_dout = 8'd0;
    logic       rd8, wr8, rd10, wr10;
    logic [7:0] din8, din10;

    int total = 0;
    int bad = 0;
    logic [7:0] in_q[$];
    int exp_q[$];
    int got[100];
    int nwr;
    int pix[100];
    int kern[25] = '{2, 4, 5, 4, 2,  4, 9, 12, 9, 4,  5, 12, 15, 12, 5,
                     4, 9, 12, 9, 4,  2, 4, 5, 4, 2};

    always #5 clk = ~clk;

    gaussian_blur #(.IMG_WIDTH(8), .IMG_HEIGHT(8)) dut8 (
        .clk(clk), .rst(rst), .in_empty(in_empty), .in_dout(in_dout), .in_rd_en(rd8),
        .out_full(out_full), .out_wr_en(wr8), .out_din(din8));

    gaussian_blur #(.IMG_WIDTH(10), .IMG_HEIGHT(10)) dut10 (
        .clk(clk), .rst(rst), .in_empty(in_empty), .in_dout(in_dout), .in_rd_en(rd10),
        .out_full(out_full), .out_wr_en(wr10), .out_din(din10));

    // Queue the frame in pix[] and push its golden outputs
    task automatic load_frame(input int w, input int h);
        int s;
        for (int k = 0; k < w * h; k++) in_q.push_back(8'(pix[k]));
        for (int y = 0; y < h; y++) begin
            for (int x = 0; x < w; x++) begin
                if (y < 2 || y >= h - 2 || x < 2 || x >= w - 2) begin
                    exp_q.push_back(0);
                end else begin
                    s = 0;
                    for (int i = -2; i <= 2; i++)
                        for (int j = -2; j <= 2; j++)
                            s += kern[(i + 2) * 5 + (j + 2)] * pix[(y + i) * w + x + j];
                    exp_q.push_back(s / 159);
                end
            end
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        in_empty = 1'b1;
        out_full = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        in_q.delete();
        exp_q.delete();
    endtask

    task automatic run_stream(input bit sel, input bit stall, input int budget);
        int cyc = 0;
        int want;
        logic rd, wr;
        logic [7:0] d;
        nwr = 0;
        for (int k = 0; k < 100; k++) got[k] = -1;
        while (exp_q.size() > 0 && cyc < budget) begin
            @(negedge clk);
            in_empty = (in_q.size() == 0) || (stall && ($urandom_range(0, 2) == 0));
            in_dout  = (in_q.size() > 0) ? in_q[0] : 8'd0;
            out_full = stall && ($urandom_range(0, 2) == 0);
            #1;
            rd = sel ? rd10 : rd8;
            wr = sel ? wr10 : wr8;
            d  = sel ? din10 : din8;
            if (rd) begin
                total++;
                if (in_empty) begin
                    bad++;
                    $display("FAIL read_while_empty: in_rd_en=%0b in_empty=%0b", rd, in_empty);
                end else begin
                    void'(in_q.pop_front());
                end
            end
            if (wr) begin
                total++;
                want = exp_q.pop_front();
                if (out_full) begin
                    bad++;
                    $display("FAIL write_while_full: out_wr_en=%0b out_full=%0b", wr, out_full);
                end else if (d !== 8'(want)) begin
                    bad++;
                    $display("FAIL pixel[%0d]: got %0d want %0d", nwr, d, want);
                end
                if (nwr < 100) got[nwr] = int'(d);
                nwr++;
            end
            cyc++;
        end
        if (exp_q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL timeout: outputs pending %0d want 0", exp_q.size());
            exp_q.delete();
        end
        out_full = 1'b0;
    endtask

    // No writes may appear once the frame is complete and input is idle
    task automatic check_idle(input bit sel, input int n);
        int extra = 0;
        in_empty = 1'b1;
        repeat (n) begin
            @(negedge clk);
            #1;
            if (sel ? wr10 : wr8) extra++;
        end
        total++;
        if (extra !== 0) begin
            bad++;
            $display("FAIL extra_writes: got %0d want 0", extra);
        end
    endtask

    task automatic check_count(input int want);
        total++;
        if (nwr !== want) begin
            bad++;
            $display("FAIL write_count: got %0d want %0d", nwr, want);
        end
    endtask

    task automatic spot(input string name, input int idx, input int want);
        total++;
        if (got[idx] !== want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, got[idx], want);
        end
    endtask

    task automatic test_reset();
        in_empty = 1'b0;
        in_dout  = 8'h5a;
        out_full = 1'b0;
        repeat (3) begin
            @(negedge clk);
            #1;
            total++;
            if ({rd8, wr8, rd10, wr10} !== 4'b0 || din8 !== 8'd0 || din10 !== 8'd0) begin
                bad++;
                $display("FAIL reset_outputs: got rd/wr=%b din8=%0d din10=%0d want 0",
                         {rd8, wr8, rd10, wr10}, din8, din10);
            end
        end
        rst = 1'b0;
        #1;
        total++;
        if (rd8 !== 1'b1) begin
            bad++;
            $display("FAIL first_read: got %0b want 1", rd8);
        end
    endtask

    task automatic test_flat(input int v);
        apply_reset();
        for (int k = 0; k < 64; k++) pix[k] = v;
        load_frame(8, 8);
        run_stream(1'b0, 1'b0, 3000);
        check_count(64);
        spot("flat_2_2", 2 * 8 + 2, v);
        spot("flat_5_5", 5 * 8 + 5, v);
        spot("flat_1_3", 1 * 8 + 3, 0);
        spot("flat_6_4", 6 * 8 + 4, 0);
        check_idle(1'b0, 40);
    endtask

    task automatic test_impulse();
        apply_reset();
        for (int k = 0; k < 100; k++) pix[k] = 0;
        pix[4 * 10 + 4] = 159;
        load_frame(10, 10);
        run_stream(1'b1, 1'b0, 4000);
        check_count(100);
        spot("imp_4_4", 44, 15);
        spot("imp_4_5", 45, 12);
        spot("imp_3_3", 33, 9);
        spot("imp_2_2", 22, 2);
        spot("imp_5_5", 55, 9);
        spot("imp_5_6", 56, 4);
    endtask

    task automatic test_random_stall();
        apply_reset();
        for (int k = 0; k < 64; k++) pix[k] = int'($urandom_range(0, 255));
        load_frame(8, 8);
        run_stream(1'b0, 1'b1, 8000);
        check_count(64);
        check_idle(1'b0, 40);
    endtask

    task automatic test_back_to_back();
        apply_reset();
        for (int k = 0; k < 64; k++) pix[k] = int'($urandom_range(0, 255));
        load_frame(8, 8);
        for (int k = 0; k < 64; k++) pix[k] = int'($urandom_range(0, 255));
        load_frame(8, 8);
        run_stream(1'b0, 1'b1, 16000);
        check_count(128);
        check_idle(1'b0, 40);
    endtask

    task automatic test_reset_midframe();
        int reads = 0;
        int cyc = 0;
        apply_reset();
        out_full = 1'b0;
        while (reads < 20 && cyc < 2000) begin
            @(negedge clk);
            in_empty = 1'b0;
            in_dout  = 8'($urandom_range(0, 255));
            #1;
            if (rd8) reads++;
            cyc++;
        end
        total++;
        if (reads !== 20) begin
            bad++;
            $display("FAIL partial_reads: got %0d want 20", reads);
        end
        @(negedge clk);
        rst = 1'b1;
        in_empty = 1'b0;
        repeat (3) begin
            #1;
            total++;
            if (rd8 !== 1'b0 || wr8 !== 1'b0) begin
                bad++;
                $display("FAIL midframe_reset: got rd=%0b wr=%0b want 0", rd8, wr8);
            end
            @(negedge clk);
        end
        rst = 1'b0;
        in_empty = 1'b1;
        for (int k = 0; k < 64; k++) pix[k] = int'($urandom_range(0, 255));
        load_frame(8, 8);
        run_stream(1'b0, 1'b0, 3000);
        check_count(64);
        check_idle(1'b0, 40);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        test_reset();
        test_flat(100);
        test_flat(255);
        test_impulse();
        test_random_stall();
        test_back_to_back();
        test_reset_midframe();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
